// File: rtl/regfile_wr_arbiter_if.sv
// Write-port bus of the register file arbiter: WB and LU write requests,
// clear control, hazard lookups and the registered regfile write port.
interface regfile_wr_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              clr_req;
  logic              clr_busy;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              lu_valid;
  logic              lu_ready;
  logic [ADDR_W-1:0] lu_addr;
  logic [DATA_W-1:0] lu_data;
  logic [ADDR_W-1:0] qry_addr_a;
  logic [ADDR_W-1:0] qry_addr_b;
  logic              qry_hit_a;
  logic              qry_hit_b;
  logic              rf_en_w;
  logic [ADDR_W-1:0] rf_addr_w;
  logic [DATA_W-1:0] rf_data_w;

  modport master (
    output clr_req, wb_en, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
           qry_addr_a, qry_addr_b,
    input  clr_busy, lu_ready, qry_hit_a, qry_hit_b, rf_en_w, rf_addr_w, rf_data_w
  );

  modport slave (
    input  clr_req, wb_en, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
           qry_addr_a, qry_addr_b,
    output clr_busy, lu_ready, qry_hit_a, qry_hit_b, rf_en_w, rf_addr_w, rf_data_w
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Shares the single regfile write port between the WB stage and the LU,
// buffers LU writes in a small FIFO and sequences r1..r31 clearing.
module regfile_wr_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wr_arbiter_if.slave  bus
);
  localparam int                PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int                CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(BUF_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_NORMAL = 1'b1} state_t;

  state_t              state_r, state_nxt_s;
  logic [ADDR_W-1:0]   clr_cnt_r, clr_cnt_nxt_s;
  logic [ADDR_W-1:0]   buf_addr_r [BUF_DEPTH];
  logic [DATA_W-1:0]   buf_data_r [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] buf_vld_r, buf_vld_nxt_s;
  logic [PTR_W-1:0]    rd_ptr_r, wr_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic                sel_en_s, wb_sel_s, pop_s, push_s, flush_s, lu_ready_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic                hit_a_s, hit_b_s;
  logic                rf_en_r;
  logic [ADDR_W-1:0]   rf_addr_r;
  logic [DATA_W-1:0]   rf_data_r;

  assign lu_ready_s = rst_n && (state_r == ST_NORMAL) && (count_r < DEPTH_C);
  assign push_s     = bus.lu_valid && lu_ready_s && (bus.lu_addr != '0);

  // Next-state and write-port selection: clear sweep, else WB over FIFO head
  always_comb begin
    state_nxt_s   = state_r;
    clr_cnt_nxt_s = clr_cnt_r;
    sel_en_s      = 1'b0;
    sel_addr_s    = '0;
    sel_data_s    = '0;
    wb_sel_s      = 1'b0;
    pop_s         = 1'b0;
    flush_s       = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        sel_en_s   = 1'b1;
        sel_addr_s = clr_cnt_r;
        if (clr_cnt_r == ADDR_LAST) begin
          state_nxt_s   = ST_NORMAL;
          clr_cnt_nxt_s = ADDR_ONE;
        end else begin
          clr_cnt_nxt_s = clr_cnt_r + ADDR_ONE;
        end
      end
      ST_NORMAL: begin
        if (bus.wb_en && (bus.wb_addr != '0)) begin
          wb_sel_s   = 1'b1;
          sel_en_s   = 1'b1;
          sel_addr_s = bus.wb_addr;
          sel_data_s = bus.wb_data;
        end else if (count_r != '0) begin
          // An entry killed by a younger WB write drains without a write
          pop_s      = 1'b1;
          sel_en_s   = buf_vld_r[rd_ptr_r];
          sel_addr_s = buf_addr_r[rd_ptr_r];
          sel_data_s = buf_data_r[rd_ptr_r];
        end else begin
          sel_en_s = 1'b0;
        end
        if (bus.clr_req) begin
          state_nxt_s   = ST_CLEAR;
          clr_cnt_nxt_s = ADDR_ONE;
          flush_s       = 1'b1;
        end else begin
          state_nxt_s = ST_NORMAL;
        end
      end
      default: begin
        state_nxt_s   = ST_CLEAR;
        clr_cnt_nxt_s = ADDR_ONE;
        flush_s       = 1'b1;
      end
    endcase
  end

  // Entry valid bits: WB invalidation, then head pop, then tail push
  always_comb begin
    buf_vld_nxt_s = buf_vld_r;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      buf_vld_nxt_s[i] = buf_vld_r[i] & ~(wb_sel_s && (buf_addr_r[i] == bus.wb_addr));
    end
    buf_vld_nxt_s[rd_ptr_r] = buf_vld_nxt_s[rd_ptr_r] & ~pop_s;
    buf_vld_nxt_s[wr_ptr_r] = buf_vld_nxt_s[wr_ptr_r] | push_s;
  end

  // Hazard lookup over live FIFO entries
  always_comb begin
    hit_a_s = 1'b0;
    hit_b_s = 1'b0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      hit_a_s = hit_a_s | (buf_vld_r[i] & (buf_addr_r[i] == bus.qry_addr_a));
      hit_b_s = hit_b_s | (buf_vld_r[i] & (buf_addr_r[i] == bus.qry_addr_b));
    end
  end

  // State, clear counter and registered write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_CLEAR;
      clr_cnt_r <= ADDR_ONE;
      rf_en_r   <= 1'b0;
      rf_addr_r <= '0;
      rf_data_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      clr_cnt_r <= clr_cnt_nxt_s;
      rf_en_r   <= sel_en_s;
      rf_addr_r <= sel_addr_s;
      rf_data_r <= sel_data_s;
    end
  end

  // FIFO control: pointers, occupancy and valid bits
  always_ff @(posedge clk) begin
    if (!rst_n || flush_s) begin
      rd_ptr_r  <= '0;
      wr_ptr_r  <= '0;
      count_r   <= '0;
      buf_vld_r <= '0;
    end else begin
      rd_ptr_r  <= rd_ptr_r + PTR_W'(pop_s);
      wr_ptr_r  <= wr_ptr_r + PTR_W'(push_s);
      count_r   <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      buf_vld_r <= buf_vld_nxt_s;
    end
  end

  // FIFO payload storage, qualified by the valid bits
  always_ff @(posedge clk) begin
    if (push_s) begin
      buf_addr_r[wr_ptr_r] <= bus.lu_addr;
      buf_data_r[wr_ptr_r] <= bus.lu_data;
    end
  end

  assign bus.clr_busy  = !rst_n || (state_r == ST_CLEAR);
  assign bus.lu_ready  = lu_ready_s;
  assign bus.qry_hit_a = (state_r == ST_NORMAL) && (bus.qry_addr_a != '0) && hit_a_s;
  assign bus.qry_hit_b = (state_r == ST_NORMAL) && (bus.qry_addr_b != '0) && hit_b_s;
  assign bus.rf_en_w   = rf_en_r;
  assign bus.rf_addr_w = rf_addr_r;
  assign bus.rf_data_w = rf_data_r;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized and directed bench for regfile_wr_arbiter against a queue-based
// model of the write-port sharing rules.
module tb_regfile_wr_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  regfile_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {int addr; logic [31:0] data; bit live;} ent_t;
  ent_t mq[$];
  ent_t hd;
  bit   m_clear = 1'b1;
  int   m_next = 1;
  int   n_vec = 0, n_err = 0;
  bit   e_busy, e_ready, e_ha, e_hb, e_en, e_ad;
  int   e_addr;
  logic [31:0] e_data;
  logic o_busy, o_ready, o_ha, o_hb;

  function automatic bit m_hit(int a);
    if (m_clear || a == 0) return 1'b0;
    foreach (mq[i]) if (mq[i].live && mq[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_idle();
    bus.clr_req = 1'b0; bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.lu_valid = 1'b0; bus.lu_addr = '0; bus.lu_data = '0;
    bus.qry_addr_a = '0; bus.qry_addr_b = '0;
  endtask

  // One clock: predict status outputs, sample them, then advance the model.
  task automatic tick();
    e_busy  = !rst_n || m_clear;
    e_ready = rst_n && !m_clear && (mq.size() < DEPTH);
    e_ha    = m_hit(int'(bus.qry_addr_a));
    e_hb    = m_hit(int'(bus.qry_addr_b));
    @(negedge clk);
    o_busy = bus.clr_busy; o_ready = bus.lu_ready; o_ha = bus.qry_hit_a; o_hb = bus.qry_hit_b;
    @(posedge clk);
    e_en = 1'b0; e_ad = 1'b0; e_addr = 0; e_data = 32'h0;
    if (!rst_n) begin
      m_clear = 1'b1; m_next = 1; mq.delete(); e_ad = 1'b1;
    end else if (m_clear) begin
      e_en = 1'b1; e_addr = m_next;
      if (m_next == 31) m_clear = 1'b0; else m_next++;
    end else begin
      if (bus.wb_en && bus.wb_addr != 0) begin
        e_en = 1'b1; e_addr = int'(bus.wb_addr); e_data = bus.wb_data;
        foreach (mq[i]) if (mq[i].addr == e_addr) mq[i].live = 1'b0;
      end else if (mq.size() > 0) begin
        hd = mq.pop_front();
        if (hd.live) begin e_en = 1'b1; e_addr = hd.addr; e_data = hd.data; end
      end
      if (bus.lu_valid && e_ready && bus.lu_addr != 0)
        mq.push_back('{int'(bus.lu_addr), bus.lu_data, 1'b1});
      if (bus.clr_req) begin m_clear = 1'b1; m_next = 1; mq.delete(); end
    end
    e_ad = e_ad | e_en;
    #1;
  endtask

  task automatic test_reset();
    set_idle(); rst_n = 1'b0;
    repeat (2) begin
      tick();
      n_vec++; if ({o_busy, o_ready, o_ha, o_hb} !== {e_busy, e_ready, e_ha, e_hb}) begin n_err++; $display("FAIL reset_status got %b want %b", {o_busy, o_ready, o_ha, o_hb}, {e_busy, e_ready, e_ha, e_hb}); end
      n_vec++; if (bus.rf_en_w !== 1'b0 || bus.rf_addr_w !== 5'd0 || bus.rf_data_w !== 32'd0) begin n_err++; $display("FAIL reset_rf got en=%b a=%0d d=%h want 0/0/0", bus.rf_en_w, bus.rf_addr_w, bus.rf_data_w); end
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      tick();
      n_vec++; if ({o_busy, o_ready, o_ha, o_hb} !== {e_busy, e_ready, e_ha, e_hb}) begin n_err++; $display("FAIL clear_status cyc %0d got %b want %b", i, {o_busy, o_ready, o_ha, o_hb}, {e_busy, e_ready, e_ha, e_hb}); end
      n_vec++; if (bus.rf_en_w !== e_en || (e_ad && (bus.rf_addr_w !== AW'(e_addr) || bus.rf_data_w !== e_data))) begin n_err++; $display("FAIL clear_rf cyc %0d got en=%b a=%0d d=%h want en=%b a=%0d d=%h", i, bus.rf_en_w, bus.rf_addr_w, bus.rf_data_w, e_en, e_addr, e_data); end
      if (i <= 31) begin
        n_vec++; if (bus.rf_en_w !== 1'b1 || int'(bus.rf_addr_w) != i) begin n_err++; $display("FAIL clear_seq got en=%b a=%0d want en=1 a=%0d", bus.rf_en_w, bus.rf_addr_w, i); end
      end
    end
  endtask

  task automatic test_wb_single();
    set_idle(); bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEADBEEF;
    tick();
    n_vec++; if (bus.rf_en_w !== e_en || bus.rf_addr_w !== AW'(e_addr) || bus.rf_data_w !== e_data) begin n_err++; $display("FAIL wb_single got en=%b a=%0d d=%h want en=%b a=%0d d=%h", bus.rf_en_w, bus.rf_addr_w, bus.rf_data_w, e_en, e_addr, e_data); end
    n_vec++; if (bus.rf_data_w !== 32'hDEADBEEF) begin n_err++; $display("FAIL wb_data got %h want deadbeef", bus.rf_data_w); end
    set_idle(); tick();
    n_vec++; if (bus.rf_en_w !== 1'b0) begin n_err++; $display("FAIL wb_hold got en=%b want 0", bus.rf_en_w); end
  endtask

  task automatic test_lu_backpressure();
    int lst[3] = '{7, 8, 9};
    int k = 0;
    int wr[$];
    set_idle(); bus.wb_en = 1'b1; bus.wb_addr = 5'd20; bus.wb_data = $urandom;
    bus.qry_addr_a = 5'd7; bus.qry_addr_b = 5'd8;
    bus.lu_valid = 1'b1; bus.lu_addr = 5'd7; bus.lu_data = $urandom;
    for (int c = 0; c < 8; c++) begin
      if (c == 4) bus.wb_en = 1'b0;
      tick();
      n_vec++; if ({o_busy, o_ready, o_ha, o_hb} !== {e_busy, e_ready, e_ha, e_hb}) begin n_err++; $display("FAIL bp_status cyc %0d got %b want %b", c, {o_busy, o_ready, o_ha, o_hb}, {e_busy, e_ready, e_ha, e_hb}); end
      n_vec++; if (bus.rf_en_w !== e_en || (e_ad && (bus.rf_addr_w !== AW'(e_addr) || bus.rf_data_w !== e_data))) begin n_err++; $display("FAIL bp_rf cyc %0d got en=%b a=%0d d=%h want en=%b a=%0d d=%h", c, bus.rf_en_w, bus.rf_addr_w, bus.rf_data_w, e_en, e_addr, e_data); end
      if (c == 3) begin
        n_vec++; if ({o_ready, o_ha, o_hb} !== 3'b011) begin n_err++; $display("FAIL bp_full got ready/hit_a/hit_b=%b want 011", {o_ready, o_ha, o_hb}); end
      end
      if (c >= 4 && bus.rf_en_w === 1'b1) wr.push_back(int'(bus.rf_addr_w));
      if (bus.lu_valid && e_ready) k++;
      if (k < 3) begin bus.lu_addr = AW'(lst[k]); bus.lu_data = $urandom; end
      else bus.lu_valid = 1'b0;
    end
    n_vec++; if (wr.size() != 3 || wr[0] != 7 || wr[1] != 8 || wr[2] != 9) begin n_err++; $display("FAIL bp_order got %0d writes %p want 7 8 9", wr.size(), wr); end
  endtask

  task automatic test_wb_invalidate();
    for (int c = 0; c < 4; c++) begin
      set_idle(); bus.qry_addr_a = 5'd10;
      if (c == 0) begin bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.lu_valid = 1'b1; bus.lu_addr = 5'd10; bus.lu_data = 32'h1; end
      if (c == 1) begin bus.wb_en = 1'b1; bus.wb_addr = 5'd10; bus.wb_data = 32'h2; end
      tick();
      n_vec++; if ({o_busy, o_ready, o_ha, o_hb} !== {e_busy, e_ready, e_ha, e_hb}) begin n_err++; $display("FAIL inv_status cyc %0d got %b want %b", c, {o_busy, o_ready, o_ha, o_hb}, {e_busy, e_ready, e_ha, e_hb}); end
      n_vec++; if (bus.rf_en_w !== e_en || (e_ad && (bus.rf_addr_w !== AW'(e_addr) || bus.rf_data_w !== e_data))) begin n_err++; $display("FAIL inv_rf cyc %0d got en=%b a=%0d d=%h want en=%b a=%0d d=%h", c, bus.rf_en_w, bus.rf_addr_w, bus.rf_data_w, e_en, e_addr, e_data); end
      if (c == 1) begin
        n_vec++; if (o_ha !== 1'b1 || bus.rf_data_w !== 32'h2) begin n_err++; $display("FAIL inv_wb got hit=%b d=%h want hit=1 d=2", o_ha, bus.rf_data_w); end
      end
      if (c >= 2) begin
        n_vec++; if (o_ha !== 1'b0 || bus.rf_en_w !== 1'b0) begin n_err++; $display("FAIL inv_drop got hit=%b en=%b want 0 0", o_ha, bus.rf_en_w); end
      end
    end
  endtask

  task automatic test_clear_restart();
    int k = 0;
    set_idle(); bus.wb_en = 1'b1; bus.wb_addr = 5'd4; bus.qry_addr_a = 5'd11;
    bus.lu_valid = 1'b1; bus.lu_addr = 5'd11; bus.lu_data = $urandom;
    for (int c = 0; c < 50; c++) begin
      if (c == 2) begin bus.lu_valid = 1'b0; bus.clr_req = 1'b1; end
      if (c == 3) begin bus.clr_req = 1'b0; bus.wb_en = 1'b0; end
      if (c == 17) rst_n = 1'b0;
      if (c == 18) rst_n = 1'b1;
      tick();
      n_vec++; if ({o_busy, o_ready, o_ha, o_hb} !== {e_busy, e_ready, e_ha, e_hb}) begin n_err++; $display("FAIL clr_status cyc %0d got %b want %b", c, {o_busy, o_ready, o_ha, o_hb}, {e_busy, e_ready, e_ha, e_hb}); end
      n_vec++; if (bus.rf_en_w !== e_en || (e_ad && (bus.rf_addr_w !== AW'(e_addr) || bus.rf_data_w !== e_data))) begin n_err++; $display("FAIL clr_rf cyc %0d got en=%b a=%0d d=%h want en=%b a=%0d d=%h", c, bus.rf_en_w, bus.rf_addr_w, bus.rf_data_w, e_en, e_addr, e_data); end
      if (c == 16) begin
        n_vec++; if (bus.rf_addr_w !== 5'd14) begin n_err++; $display("FAIL clr_mid got a=%0d want 14", bus.rf_addr_w); end
      end
      if (c == 18) begin
        n_vec++; if (bus.rf_en_w !== 1'b1 || bus.rf_addr_w !== 5'd1) begin n_err++; $display("FAIL clr_restart got en=%b a=%0d want en=1 a=1", bus.rf_en_w, bus.rf_addr_w); end
      end
      if (c < 2 && bus.lu_valid && e_ready) begin k++; bus.lu_addr = 5'd12; bus.lu_data = $urandom; end
    end
  endtask

  task automatic test_lu_zero();
    for (int c = 0; c < 3; c++) begin
      set_idle(); bus.qry_addr_b = 5'd0;
      if (c == 0) begin bus.lu_valid = 1'b1; bus.lu_addr = 5'd0; bus.lu_data = $urandom; end
      tick();
      n_vec++; if ({o_busy, o_ready, o_ha, o_hb} !== {e_busy, e_ready, e_ha, e_hb}) begin n_err++; $display("FAIL zero_status cyc %0d got %b want %b", c, {o_busy, o_ready, o_ha, o_hb}, {e_busy, e_ready, e_ha, e_hb}); end
      n_vec++; if (bus.rf_en_w !== 1'b0 || o_ready !== 1'b1 || o_hb !== 1'b0) begin n_err++; $display("FAIL zero_drop got en=%b ready=%b hit=%b want 0 1 0", bus.rf_en_w, o_ready, o_hb); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      rst_n         = ($urandom_range(0, 299) != 0);
      bus.clr_req   = ($urandom_range(0, 79) == 0);
      bus.wb_en     = ($urandom_range(0, 1) == 0);
      bus.wb_addr   = AW'($urandom_range(0, 7));
      bus.wb_data   = $urandom;
      bus.lu_valid  = ($urandom_range(0, 4) < 3);
      bus.lu_addr   = AW'($urandom_range(0, 7));
      bus.lu_data   = $urandom;
      bus.qry_addr_a = AW'($urandom_range(0, 7));
      bus.qry_addr_b = AW'($urandom_range(0, 7));
      tick();
      n_vec++; if ({o_busy, o_ready, o_ha, o_hb} !== {e_busy, e_ready, e_ha, e_hb}) begin n_err++; $display("FAIL rnd_status cyc %0d got %b want %b", c, {o_busy, o_ready, o_ha, o_hb}, {e_busy, e_ready, e_ha, e_hb}); end
      n_vec++; if (bus.rf_en_w !== e_en || (e_ad && (bus.rf_addr_w !== AW'(e_addr) || bus.rf_data_w !== e_data))) begin n_err++; $display("FAIL rnd_rf cyc %0d got en=%b a=%0d d=%h want en=%b a=%0d d=%h", c, bus.rf_en_w, bus.rf_addr_w, bus.rf_data_w, e_en, e_addr, e_data); end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    set_idle();
    test_reset();
    test_wb_single();
    test_lu_backpressure();
    test_wb_invalidate();
    test_lu_zero();
    test_clear_restart();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
